// File: rtl/onfi_nand_master.sv
// onfi_nand_master: byte-wide NAND controller sequencing reset, read-ID and page read into local buffers
// Ports: clk/rst_n (async active-low); host side activate/cmd_in/data_in/enable -> data_out/busy;
//        NAND side cle/ale/nwe/nre/nce/nwp outputs, rnb input, nand_data[7:0] bidirectional ([15:8] always Z)
module onfi_nand_master #(
    parameter int T_WP       = 4,
    parameter int T_RP       = 4,
    parameter int T_WB       = 40,
    parameter int PAGE_BYTES = 528,
    parameter int ID_BYTES   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        activate,
    input  logic [5:0]  cmd_in,
    input  logic [7:0]  data_in,
    input  logic        enable,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        nand_cle,
    output logic        nand_ale,
    output logic        nand_nwe,
    output logic        nand_nre,
    output logic        nand_nce,
    output logic        nand_nwp,
    input  logic        nand_rnb,
    inout  wire  [15:0] nand_data
);
    localparam int PW = $clog2(PAGE_BYTES);
    localparam int IW = $clog2(ID_BYTES);
    localparam int CW = $clog2(T_WB + 2 * T_WP + 2 * T_RP + 1);
    localparam logic [5:0] M_RESET               = 6'h01;
    localparam logic [5:0] M_NAND_RESET          = 6'h04;
    localparam logic [5:0] M_NAND_READ_ID        = 6'h06;
    localparam logic [5:0] M_NAND_READ           = 6'h09;
    localparam logic [5:0] MI_GET_STATUS         = 6'h0D;
    localparam logic [5:0] MI_CHIP_ENABLE        = 6'h0E;
    localparam logic [5:0] MI_RESET_INDEX        = 6'h12;
    localparam logic [5:0] MI_GET_ID_BYTE        = 6'h13;
    localparam logic [5:0] MI_SET_ADDR_BYTE      = 6'h14;
    localparam logic [5:0] MI_GET_DATA_PAGE_BYTE = 6'h15;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WAIT_WB, S_WAIT_RDY, S_READ, S_DONE} state_t;
    typedef enum logic [1:0] {OP_RST, OP_ID, OP_RD} op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      acnt_q, acnt_d;
    logic [PW-1:0]   rcnt_q, rcnt_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   pg_idx_q, pg_idx_d;
    logic [IW-1:0]   id_idx_q, id_idx_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      cmd_byte_q, cmd_byte_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            nce_q, nce_d;
    logic            busy_q, busy_d;
    logic            cle_q, cle_d;
    logic            ale_q, ale_d;
    logic            nwe_q, nwe_d;
    logic            nre_q, nre_d;
    logic            oe_q, oe_d;
    logic            accept, strobe_end, last_rd, page_we, id_we;
    logic [7:0]      page_mem [PAGE_BYTES];
    logic [7:0]      id_mem [ID_BYTES];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acnt_d     = acnt_q;
        rcnt_d     = rcnt_q;
        wptr_d     = wptr_q;
        pg_idx_d   = pg_idx_q;
        id_idx_d   = id_idx_q;
        addr_d     = addr_q;
        cmd_byte_d = cmd_byte_q;
        nce_d      = nce_q;
        dout_d     = dout_q;
        page_we    = 1'b0;
        id_we      = 1'b0;
        accept     = activate && !enable && state_q == S_IDLE;
        strobe_end = cnt_q == CW'(2 * T_WP);
        last_rd    = rcnt_q == (op_q == OP_ID ? PW'(ID_BYTES - 1) : PW'(PAGE_BYTES - 1));
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_in == M_RESET) begin
                        pg_idx_d = '0;
                        id_idx_d = '0;
                        addr_d   = '0;
                        nce_d    = 1'b1;
                        dout_d   = '0;
                    end else if (cmd_in == MI_CHIP_ENABLE) begin
                        nce_d = data_in != 8'h00;
                    end else if (cmd_in == MI_GET_STATUS) begin
                        dout_d = {4'b0000, nand_nwp, !nce_q, nand_rnb, busy_q};
                    end else if (cmd_in == MI_RESET_INDEX) begin
                        pg_idx_d = '0;
                        id_idx_d = '0;
                    end else if (cmd_in == MI_GET_ID_BYTE) begin
                        dout_d   = id_mem[id_idx_q];
                        id_idx_d = id_idx_q == IW'(ID_BYTES - 1) ? '0 : id_idx_q + IW'(1);
                    end else if (cmd_in == MI_GET_DATA_PAGE_BYTE) begin
                        dout_d   = page_mem[pg_idx_q];
                        pg_idx_d = pg_idx_q == PW'(PAGE_BYTES - 1) ? '0 : pg_idx_q + PW'(1);
                    end else if (cmd_in == MI_SET_ADDR_BYTE) begin
                        addr_d = {addr_q[23:0], data_in};
                    end else if (!nce_q && (cmd_in == M_NAND_RESET || cmd_in == M_NAND_READ_ID ||
                                            cmd_in == M_NAND_READ)) begin
                        state_d    = S_CMD;
                        cnt_d      = '0;
                        acnt_d     = '0;
                        rcnt_d     = '0;
                        // page fill starts at the host index; the index itself is left untouched
                        wptr_d     = pg_idx_q;
                        op_d       = cmd_in == M_NAND_RESET ? OP_RST : cmd_in == M_NAND_READ_ID ? OP_ID : OP_RD;
                        cmd_byte_d = cmd_in == M_NAND_RESET ? 8'hFF : cmd_in == M_NAND_READ_ID ? 8'h90 : 8'h00;
                    end
                end
            end
            S_CMD: begin
                cnt_d = strobe_end ? '0 : cnt_q + CW'(1);
                if (strobe_end) state_d = op_q == OP_RST ? S_WAIT_WB : S_ADDR;
            end
            S_ADDR: begin
                cnt_d = strobe_end ? '0 : cnt_q + CW'(1);
                if (strobe_end) begin
                    acnt_d  = acnt_q + 2'd1;
                    state_d = op_q == OP_ID ? S_READ : acnt_q == 2'd3 ? S_WAIT_WB : S_ADDR;
                end
            end
            S_WAIT_WB: begin
                cnt_d   = cnt_q == CW'(T_WB - 1) ? '0 : cnt_q + CW'(1);
                state_d = cnt_q == CW'(T_WB - 1) ? S_WAIT_RDY : S_WAIT_WB;
            end
            S_WAIT_RDY: begin
                if (nand_rnb) state_d = op_q == OP_RST ? S_DONE : S_READ;
            end
            S_READ: begin
                // capture on the last low cycle of nre
                page_we = cnt_q == CW'(T_RP - 1) && op_q == OP_RD;
                id_we   = cnt_q == CW'(T_RP - 1) && op_q == OP_ID;
                cnt_d   = cnt_q == CW'(2 * T_RP - 1) ? '0 : cnt_q + CW'(1);
                if (cnt_q == CW'(2 * T_RP - 1)) begin
                    rcnt_d = rcnt_q + PW'(1);
                    wptr_d = wptr_q == PW'(PAGE_BYTES - 1) ? '0 : wptr_q + PW'(1);
                    if (last_rd) begin
                        state_d  = S_DONE;
                        id_idx_d = op_q == OP_ID ? '0 : id_idx_q;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // bus pins derive from the next state so they are registered without lagging the FSM
        busy_d  = state_d != S_IDLE;
        cle_d   = state_d == S_CMD;
        ale_d   = state_d == S_ADDR;
        oe_d    = cle_d || ale_d;
        nwe_d   = !(oe_d && cnt_d != '0 && cnt_d <= CW'(T_WP));
        nre_d   = !(state_d == S_READ && cnt_d < CW'(T_RP));
        wdata_d = cle_d ? cmd_byte_d : op_d == OP_RD ? addr_d[{acnt_d, 3'b000} +: 8] : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_RST;
            cnt_q      <= '0;
            acnt_q     <= '0;
            rcnt_q     <= '0;
            wptr_q     <= '0;
            pg_idx_q   <= '0;
            id_idx_q   <= '0;
            addr_q     <= '0;
            cmd_byte_q <= '0;
            dout_q     <= '0;
            wdata_q    <= '0;
            nce_q      <= 1'b1;
            busy_q     <= 1'b0;
            cle_q      <= 1'b0;
            ale_q      <= 1'b0;
            nwe_q      <= 1'b1;
            nre_q      <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acnt_q     <= acnt_d;
            rcnt_q     <= rcnt_d;
            wptr_q     <= wptr_d;
            pg_idx_q   <= pg_idx_d;
            id_idx_q   <= id_idx_d;
            addr_q     <= addr_d;
            cmd_byte_q <= cmd_byte_d;
            dout_q     <= dout_d;
            wdata_q    <= wdata_d;
            nce_q      <= nce_d;
            busy_q     <= busy_d;
            cle_q      <= cle_d;
            ale_q      <= ale_d;
            nwe_q      <= nwe_d;
            nre_q      <= nre_d;
            oe_q       <= oe_d;
        end
    end

    // buffers survive both resets
    always_ff @(posedge clk) begin
        if (page_we) page_mem[wptr_q] <= nand_data[7:0];
        if (id_we) id_mem[rcnt_q[IW-1:0]] <= nand_data[7:0];
    end

    assign data_out        = dout_q;
    assign busy            = busy_q;
    assign nand_cle        = cle_q;
    assign nand_ale        = ale_q;
    assign nand_nwe        = nwe_q;
    assign nand_nre        = nre_q;
    assign nand_nce        = nce_q;
    assign nand_nwp        = 1'b0;
    assign nand_data[15:8] = 8'hzz;
    assign nand_data[7:0]  = oe_q ? wdata_q : 8'hzz;
endmodule

// File: tb/tb_onfi_nand_master.sv
// tb_onfi_nand_master: directed bench with a NAND flash model and a data_out scoreboard
module tb_onfi_nand_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        activate = 1'b0;
    logic [5:0]  cmd_in = '0;
    logic [7:0]  data_in = '0;
    logic        enable = 1'b0;
    logic [7:0]  data_out;
    logic        busy, nand_cle, nand_ale, nand_nwe, nand_nre, nand_nce, nand_nwp, nand_rnb;
    wire  [15:0] nand_data;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  cmd_log [$];
    logic [7:0]  addr_log [$];
    logic [7:0]  sb_e;

    logic        pwr_ok = 1'b0;
    logic        nwe_p = 1'b1;
    logic        nre_p = 1'b1;
    int          nwe_falls = 0;
    int          nre_falls = 0;
    int          nce_viol = 0;
    int          busy_cnt = 0;
    int          naddr = 0;
    logic [9:0]  ptr = '0;
    logic [7:0]  mcmd = 8'h00;
    logic [7:0]  model_byte;
    logic [7:0]  id_tab [5] = '{8'hEC, 8'h76, 8'h5A, 8'h3F, 8'h10};

    onfi_nand_master dut (
        .clk(clk), .rst_n(rst_n), .activate(activate), .cmd_in(cmd_in), .data_in(data_in),
        .enable(enable), .data_out(data_out), .busy(busy), .nand_cle(nand_cle), .nand_ale(nand_ale),
        .nand_nwe(nand_nwe), .nand_nre(nand_nre), .nand_nce(nand_nce), .nand_nwp(nand_nwp),
        .nand_rnb(nand_rnb), .nand_data(nand_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pgb(input int i);
        return 8'((i * 13 + 5) ^ (i >> 3));
    endfunction

    // flash model: latches bus on nwe rise, streams ID or page bytes while nre is low
    assign model_byte     = mcmd == 8'h90 ? id_tab[int'(ptr) % 5] : pgb(int'(ptr));
    assign nand_data[7:0] = (!nand_nre && !nand_nce) ? model_byte : 8'hzz;
    assign nand_rnb       = pwr_ok && busy_cnt == 0;

    always @(posedge clk) begin
        nwe_p <= nand_nwe;
        nre_p <= nand_nre;
        if (nwe_p && !nand_nwe) begin
            nwe_falls <= nwe_falls + 1;
            if (nand_nce) nce_viol <= nce_viol + 1;
        end
        if (nre_p && !nand_nre) begin
            nre_falls <= nre_falls + 1;
            if (nand_nce) nce_viol <= nce_viol + 1;
        end
        if (!nre_p && nand_nre) ptr <= ptr + 10'd1;
        if (!nwe_p && nand_nwe && nand_cle) begin
            cmd_log.push_back(nand_data[7:0]);
            mcmd  <= nand_data[7:0];
            ptr   <= '0;
            naddr <= 0;
        end
        if (!nwe_p && nand_nwe && nand_ale) begin
            addr_log.push_back(nand_data[7:0]);
            naddr <= naddr + 1;
        end
        if (!nwe_p && nand_nwe && nand_cle && nand_data[7:0] == 8'hFF) busy_cnt <= 80;
        else if (!nwe_p && nand_nwe && nand_ale && mcmd == 8'h00 && naddr == 3) busy_cnt <= 60;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] c, input logic [7:0] d);
        @(negedge clk);
        cmd_in   = c;
        data_in  = d;
        activate = 1'b1;
        @(negedge clk);
        activate = 1'b0;
    endtask

    task automatic get(input logic [5:0] c, input logic [7:0] e);
        exp_q.push_back(e);
        issue(c, 8'h00);
    endtask

    task automatic wait_idle(input int lim, input string n);
        int k = 0;
        while (busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(n, {31'd0, busy}, 32'd0);
    endtask

    // monitor: every accepted output-producing command is compared on the following negedge
    initial forever begin
        @(posedge clk);
        if (rst_n && activate && !enable && !busy && (cmd_in == 6'h0D || cmd_in == 6'h13 || cmd_in == 6'h15)) begin
            @(negedge clk);
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: data_out=%02h with no expected byte queued", data_out);
            end else begin
                sb_e = exp_q.pop_front();
                if (data_out !== sb_e) begin
                    n_fail++;
                    $display("FAIL sb_data_out: got %02h expected %02h", data_out, sb_e);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cle", {31'd0, nand_cle}, 0);
        chk("rst_ale", {31'd0, nand_ale}, 0);
        chk("rst_nwe", {31'd0, nand_nwe}, 1);
        chk("rst_nre", {31'd0, nand_nre}, 1);
        chk("rst_nce", {31'd0, nand_nce}, 1);
        chk("rst_nwp", {31'd0, nand_nwp}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_data_out", {24'd0, data_out}, 0);
        get(6'h0D, 8'h00);

        // NAND command with chip disabled is dropped
        issue(6'h04, 8'h00);
        repeat (5) @(negedge clk);
        chk("dis_busy", {31'd0, busy}, 0);
        chk("dis_strobes", nwe_falls + nre_falls, 0);
        chk("dis_cmds", cmd_log.size(), 0);

        pwr_ok = 1'b1;
        @(negedge clk);
        issue(6'h0E, 8'h00);
        chk("ce_nce", {31'd0, nand_nce}, 0);
        get(6'h0D, 8'h06);

        // NAND reset; a read-ID issued while busy must be ignored
        issue(6'h04, 8'h00);
        chk("nrst_busy_rise", {31'd0, busy}, 1);
        issue(6'h06, 8'h00);
        k = 0;
        while (nand_rnb && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("nrst_rnb_low", {31'd0, nand_rnb}, 0);
        chk("nrst_busy_while_rnb_low", {31'd0, busy}, 1);
        wait_idle(500, "nrst_timeout");
        chk("nrst_rnb_ready", {31'd0, nand_rnb}, 1);
        chk("nrst_cmd_count", cmd_log.size(), 1);
        chk("nrst_cmd_ff", {24'd0, cmd_log[0]}, 32'hFF);
        chk("nrst_nwe_count", nwe_falls, 1);
        chk("nrst_no_reads", nre_falls, 0);

        // read ID then wrap through the 5-byte buffer
        n0 = nre_falls;
        issue(6'h06, 8'h00);
        wait_idle(500, "rid_timeout");
        chk("rid_cmd", {24'd0, cmd_log[$]}, 32'h90);
        chk("rid_addr", {24'd0, addr_log[$]}, 0);
        chk("rid_reads", nre_falls - n0, 5);
        for (int i = 0; i < 8; i++) get(6'h13, id_tab[i % 5]);

        // page read at address 0 into index 0
        for (int i = 0; i < 4; i++) issue(6'h14, 8'h00);
        issue(6'h12, 8'h00);
        n0 = nre_falls;
        issue(6'h09, 8'h00);
        wait_idle(10000, "prd_timeout");
        chk("prd_cmd", {24'd0, cmd_log[$]}, 0);
        chk("prd_addr_count", addr_log.size(), 5);
        chk("prd_addr_val", {24'd0, addr_log[$]}, 0);
        chk("prd_reads", nre_falls - n0, 528);
        issue(6'h12, 8'h00);
        for (int i = 0; i <= 528; i++) get(6'h15, pgb(i % 528));

        // page read from non-zero index; address bytes leave LSB first
        issue(6'h12, 8'h00);
        for (int i = 0; i < 3; i++) get(6'h15, pgb(i));
        issue(6'h14, 8'h11);
        issue(6'h14, 8'h22);
        issue(6'h14, 8'h33);
        issue(6'h14, 8'h44);
        issue(6'h09, 8'h00);
        wait_idle(10000, "prd2_timeout");
        chk("prd2_addr0", {24'd0, addr_log[$-3]}, 32'h44);
        chk("prd2_addr1", {24'd0, addr_log[$-2]}, 32'h33);
        chk("prd2_addr2", {24'd0, addr_log[$-1]}, 32'h22);
        chk("prd2_addr3", {24'd0, addr_log[$]}, 32'h11);
        get(6'h15, pgb(0));
        get(6'h15, pgb(1));
        issue(6'h12, 8'h00);
        get(6'h15, pgb(525));

        // soft reset keeps buffers, disables chip
        issue(6'h01, 8'h00);
        chk("srst_nce", {31'd0, nand_nce}, 1);
        chk("srst_data_out", {24'd0, data_out}, 0);
        get(6'h0D, 8'h02);
        get(6'h13, 8'hEC);
        get(6'h15, pgb(525));

        // enable=1 blocks commands
        enable = 1'b1;
        issue(6'h0E, 8'h00);
        issue(6'h0D, 8'h00);
        chk("en_nce", {31'd0, nand_nce}, 1);
        chk("en_data_out", {24'd0, data_out}, {24'd0, pgb(525)});
        enable = 1'b0;

        // async reset aborts an in-flight page read
        issue(6'h0E, 8'h00);
        issue(6'h09, 8'h00);
        repeat (20) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_cle_ale", {30'd0, nand_cle, nand_ale}, 0);
        chk("abort_nwe", {31'd0, nand_nwe}, 1);
        chk("abort_nce", {31'd0, nand_nce}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("sb_drained", exp_q.size(), 0);
        chk("nce_strobe_violations", nce_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
